// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - WISC 5-stage pipeline hazard detection, stall/bubble/freeze control and stall bookkeeping
module hazard_stall_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       IFID_Rs,
    input  logic [3:0]       IFID_Rt,
    input  logic             IFID_UsesRs,
    input  logic             IFID_UsesRt,
    input  logic             IFID_MemWrite,
    input  logic             IFID_IsBR,
    input  logic             IFID_IsCondBr,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic             IDEX_SetsFlags,
    input  logic [3:0]       IDEX_Rd,
    input  logic             EXMem_MemRead,
    input  logic [3:0]       EXMem_Rd,
    input  logic             BranchTaken,
    input  logic             DMem_Busy,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             Pipe_Freeze,
    output logic [1:0]       StallCause,
    output logic [CNT_W-1:0] StallCount,
    output logic             MemTimeout
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DSTALL = 2'b01,
        FSTALL = 2'b10,
        MWAIT  = 2'b11
    } state_t;

    localparam logic [7:0] BusyLimit = 8'(TIMEOUT);

    state_t           state;
    state_t           nextState;
    logic             idexRdLive;
    logic             exmemRdLive;
    logic             rsLoadMatch;
    logic             rtLoadMatch;
    logic             loadUse;
    logic             brHazard;
    logic             flagHazard;
    logic             dataHazard;
    logic [7:0]       busyCnt;
    logic [7:0]       busyCntNext;
    logic [CNT_W-1:0] stallCnt;
    logic             memTimeoutQ;

    // R0 is hardwired zero, so a write to it can never be a true dependency
    assign idexRdLive  = (IDEX_Rd != 4'd0);
    assign exmemRdLive = (EXMem_Rd != 4'd0);

    // Store data (Rt of SW) is forwarded MEM-to-MEM, so it alone never stalls
    assign rsLoadMatch = IFID_UsesRs & (IDEX_Rd == IFID_Rs);
    assign rtLoadMatch = IFID_UsesRt & (IDEX_Rd == IFID_Rt) & ~IFID_MemWrite;
    assign loadUse     = IDEX_MemRead & idexRdLive & (rsLoadMatch | rtLoadMatch);

    // BR reads Rs in ID, before any EX forwarding path can supply it
    assign brHazard = IFID_IsBR &
                      ((IDEX_RegWrite & idexRdLive & (IDEX_Rd == IFID_Rs)) |
                       (EXMem_MemRead & exmemRdLive & (EXMem_Rd == IFID_Rs)));

    assign flagHazard = IFID_IsCondBr & IDEX_SetsFlags;
    assign dataHazard = loadUse | brHazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = RUN;
        if (DMem_Busy) begin
            nextState = MWAIT;
        end else if (dataHazard) begin
            nextState = DSTALL;
        end else if (flagHazard) begin
            nextState = FSTALL;
        end
    end

    // Same priority as the state decode, but driven straight from the inputs
    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        Pipe_Freeze = 1'b0;
        if (DMem_Busy) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            Pipe_Freeze = 1'b1;
        end else if (dataHazard || flagHazard) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else begin
            IFID_Flush  = BranchTaken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (!PC_Write && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    // Busy run length saturates so a very long wait cannot wrap back below the limit
    assign busyCntNext = (busyCnt == 8'hFF) ? 8'hFF : busyCnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busyCnt     <= 8'd0;
            memTimeoutQ <= 1'b0;
        end else if (DMem_Busy) begin
            busyCnt <= busyCntNext;
            if (busyCntNext >= BusyLimit) begin
                memTimeoutQ <= 1'b1;
            end
        end else begin
            busyCnt <= 8'd0;
        end
    end

    assign StallCause = state;
    assign StallCount = stallCnt;
    assign MemTimeout = memTimeoutQ;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;

    localparam int CW = 8;

    typedef struct packed {
        logic [3:0] rs;
        logic [3:0] rt;
        logic [1:0] uses;
        logic [2:0] idKind;
        logic [2:0] exCtl;
        logic [3:0] idexRd;
        logic       exmemRead;
        logic [3:0] exmemRd;
        logic       taken;
        logic       busy;
    } stim_t;

    // {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze}
    localparam logic [4:0] RUNO   = 5'b11000;
    localparam logic [4:0] FLUSH  = 5'b11100;
    localparam logic [4:0] STALL  = 5'b00010;
    localparam logic [4:0] FREEZE = 5'b00001;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    IFID_Rs, IFID_Rt, IDEX_Rd, EXMem_Rd;
    logic          IFID_UsesRs, IFID_UsesRt, IFID_MemWrite, IFID_IsBR, IFID_IsCondBr;
    logic          IDEX_MemRead, IDEX_RegWrite, IDEX_SetsFlags, EXMem_MemRead;
    logic          BranchTaken, DMem_Busy;
    logic          PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze;
    logic [1:0]    StallCause;
    logic [CW-1:0] StallCount;
    logic          MemTimeout;

    int nChecks = 0;
    int nFails  = 0;
    logic [6:0] sb[$];

    always #5 clk = ~clk;

    hazard_stall_unit #(.TIMEOUT(255), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_UsesRs(IFID_UsesRs), .IFID_UsesRt(IFID_UsesRt),
        .IFID_MemWrite(IFID_MemWrite), .IFID_IsBR(IFID_IsBR), .IFID_IsCondBr(IFID_IsCondBr),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
        .IDEX_SetsFlags(IDEX_SetsFlags), .IDEX_Rd(IDEX_Rd),
        .EXMem_MemRead(EXMem_MemRead), .EXMem_Rd(EXMem_Rd),
        .BranchTaken(BranchTaken), .DMem_Busy(DMem_Busy),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Bubble(IDEX_Bubble), .Pipe_Freeze(Pipe_Freeze),
        .StallCause(StallCause), .StallCount(StallCount), .MemTimeout(MemTimeout)
    );

    function automatic stim_t mk(input logic [3:0] rs, input logic [3:0] rt, input logic [1:0] uses,
                                 input logic [2:0] idKind, input logic [2:0] exCtl,
                                 input logic [3:0] idexRd, input logic exmemRead,
                                 input logic [3:0] exmemRd, input logic taken, input logic busy);
        stim_t s;
        s.rs = rs; s.rt = rt; s.uses = uses; s.idKind = idKind; s.exCtl = exCtl;
        s.idexRd = idexRd; s.exmemRead = exmemRead; s.exmemRd = exmemRd;
        s.taken = taken; s.busy = busy;
        return s;
    endfunction

    task automatic applyStim(input stim_t s);
        IFID_Rs = s.rs; IFID_Rt = s.rt;
        {IFID_UsesRs, IFID_UsesRt} = s.uses;
        {IFID_MemWrite, IFID_IsBR, IFID_IsCondBr} = s.idKind;
        {IDEX_MemRead, IDEX_RegWrite, IDEX_SetsFlags} = s.exCtl;
        IDEX_Rd = s.idexRd; EXMem_MemRead = s.exmemRead; EXMem_Rd = s.exmemRd;
        BranchTaken = s.taken; DMem_Busy = s.busy;
    endtask

    task automatic resetDut();
        @(negedge clk);
        applyStim('0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        applyStim('0);
        #1 rst = 1'b1;
        #2;
        nChecks++; if (StallCause !== 2'b00) begin nFails++; $display("FAIL reset_cause got %b want 00", StallCause); end
        nChecks++; if (StallCount !== '0) begin nFails++; $display("FAIL reset_count got %0d want 0", StallCount); end
        nChecks++; if (MemTimeout !== 1'b0) begin nFails++; $display("FAIL reset_timeout got %b want 0", MemTimeout); end
        nChecks++;
        if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze} !== RUNO) begin
            nFails++;
            $display("FAIL reset_outputs got %b want %b",
                     {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze}, RUNO);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [6:0] ex[$];
        logic [6:0] e;
        resetDut();
        st.push_back(mk(4'd3, 4'd7, 2'b11, 3'b000, 3'b110, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0)); ex.push_back({STALL, 2'b00});
        st.push_back(mk(4'd3, 4'd7, 2'b11, 3'b000, 3'b000, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0)); ex.push_back({RUNO, 2'b01});
        st.push_back(mk(4'd5, 4'd3, 2'b11, 3'b000, 3'b110, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0)); ex.push_back({STALL, 2'b00});
        st.push_back('0);                                                                  ex.push_back({RUNO, 2'b01});
        for (int k = 0; k < st.size(); k++) begin
            @(posedge clk); #1;
            applyStim(st[k]);
            sb.push_back(ex[k]);
            @(negedge clk);
            e = sb.pop_front();
            nChecks++;
            if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, StallCause} !== e) begin
                nFails++;
                $display("FAIL load_use step %0d got %b want %b", k,
                         {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, StallCause}, e);
            end
        end
        nChecks++; if (StallCount !== 8'd2) begin nFails++; $display("FAIL load_use_count got %0d want 2", StallCount); end
    endtask

    task automatic test_store_data();
        stim_t st[$];
        logic [6:0] ex[$];
        logic [6:0] e;
        resetDut();
        st.push_back(mk(4'd5, 4'd3, 2'b11, 3'b100, 3'b110, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0)); ex.push_back({RUNO, 2'b00});
        st.push_back(mk(4'd0, 4'd0, 2'b11, 3'b000, 3'b110, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0)); ex.push_back({RUNO, 2'b00});
        st.push_back(mk(4'd3, 4'd3, 2'b11, 3'b100, 3'b110, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0)); ex.push_back({STALL, 2'b00});
        st.push_back('0);                                                                  ex.push_back({RUNO, 2'b01});
        for (int k = 0; k < st.size(); k++) begin
            @(posedge clk); #1;
            applyStim(st[k]);
            sb.push_back(ex[k]);
            @(negedge clk);
            e = sb.pop_front();
            nChecks++;
            if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, StallCause} !== e) begin
                nFails++;
                $display("FAIL store_data step %0d got %b want %b", k,
                         {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, StallCause}, e);
            end
        end
        nChecks++; if (StallCount !== 8'd1) begin nFails++; $display("FAIL store_data_count got %0d want 1", StallCount); end
    endtask

    task automatic test_br_hazards();
        stim_t st[$];
        logic [6:0] ex[$];
        logic [6:0] e;
        resetDut();
        st.push_back(mk(4'd4, 4'd0, 2'b10, 3'b010, 3'b110, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0)); ex.push_back({STALL, 2'b00});
        st.push_back(mk(4'd4, 4'd0, 2'b10, 3'b010, 3'b000, 4'd0, 1'b1, 4'd4, 1'b0, 1'b0)); ex.push_back({STALL, 2'b01});
        st.push_back(mk(4'd4, 4'd0, 2'b10, 3'b010, 3'b000, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0)); ex.push_back({FLUSH, 2'b01});
        st.push_back(mk(4'd0, 4'd0, 2'b10, 3'b010, 3'b110, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0)); ex.push_back({RUNO, 2'b00});
        st.push_back(mk(4'd0, 4'd0, 2'b10, 3'b010, 3'b000, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0)); ex.push_back({RUNO, 2'b00});
        st.push_back(mk(4'd6, 4'd0, 2'b10, 3'b010, 3'b010, 4'd6, 1'b0, 4'd0, 1'b0, 1'b0)); ex.push_back({STALL, 2'b00});
        st.push_back(mk(4'd6, 4'd0, 2'b10, 3'b010, 3'b000, 4'd0, 1'b0, 4'd6, 1'b0, 1'b0)); ex.push_back({RUNO, 2'b01});
        for (int k = 0; k < st.size(); k++) begin
            @(posedge clk); #1;
            applyStim(st[k]);
            sb.push_back(ex[k]);
            @(negedge clk);
            e = sb.pop_front();
            nChecks++;
            if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, StallCause} !== e) begin
                nFails++;
                $display("FAIL br_hazard step %0d got %b want %b", k,
                         {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, StallCause}, e);
            end
            if (k == 2) begin
                nChecks++;
                if (StallCount !== 8'd2) begin nFails++; $display("FAIL br_load_count got %0d want 2", StallCount); end
            end
        end
        nChecks++; if (StallCount !== 8'd3) begin nFails++; $display("FAIL br_total_count got %0d want 3", StallCount); end
    endtask

    task automatic test_flags();
        stim_t st[$];
        logic [6:0] ex[$];
        logic [6:0] e;
        resetDut();
        st.push_back(mk(4'd0, 4'd0, 2'b00, 3'b001, 3'b011, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0)); ex.push_back({STALL, 2'b00});
        st.push_back(mk(4'd0, 4'd0, 2'b00, 3'b001, 3'b000, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0)); ex.push_back({FLUSH, 2'b10});
        st.push_back('0);                                                                  ex.push_back({RUNO, 2'b00});
        for (int k = 0; k < st.size(); k++) begin
            @(posedge clk); #1;
            applyStim(st[k]);
            sb.push_back(ex[k]);
            @(negedge clk);
            e = sb.pop_front();
            nChecks++;
            if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, StallCause} !== e) begin
                nFails++;
                $display("FAIL flags step %0d got %b want %b", k,
                         {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, StallCause}, e);
            end
        end
        nChecks++; if (StallCount !== 8'd1) begin nFails++; $display("FAIL flags_count got %0d want 1", StallCount); end
    endtask

    task automatic test_mem_wait();
        stim_t st[$];
        logic [6:0] ex[$];
        logic [6:0] e;
        resetDut();
        st.push_back(mk(4'd3, 4'd0, 2'b10, 3'b000, 3'b110, 4'd3, 1'b0, 4'd0, 1'b1, 1'b1)); ex.push_back({FREEZE, 2'b00});
        st.push_back(mk(4'd3, 4'd0, 2'b10, 3'b000, 3'b110, 4'd3, 1'b0, 4'd0, 1'b1, 1'b1)); ex.push_back({FREEZE, 2'b11});
        st.push_back(mk(4'd3, 4'd0, 2'b10, 3'b000, 3'b110, 4'd3, 1'b0, 4'd0, 1'b1, 1'b1)); ex.push_back({FREEZE, 2'b11});
        st.push_back(mk(4'd3, 4'd0, 2'b10, 3'b000, 3'b110, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0)); ex.push_back({STALL, 2'b11});
        st.push_back(mk(4'd3, 4'd0, 2'b10, 3'b000, 3'b000, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0)); ex.push_back({RUNO, 2'b01});
        for (int k = 0; k < st.size(); k++) begin
            @(posedge clk); #1;
            applyStim(st[k]);
            sb.push_back(ex[k]);
            @(negedge clk);
            e = sb.pop_front();
            nChecks++;
            if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, StallCause} !== e) begin
                nFails++;
                $display("FAIL mem_wait step %0d got %b want %b", k,
                         {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, StallCause}, e);
            end
        end
        nChecks++; if (StallCount !== 8'd4) begin nFails++; $display("FAIL mem_wait_count got %0d want 4", StallCount); end
    endtask

    task automatic test_timeout_reset();
        stim_t busyOnly;
        stim_t busyHaz;
        logic [6:0] e;
        busyOnly = mk(4'd0, 4'd0, 2'b00, 3'b000, 3'b000, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        busyHaz  = mk(4'd3, 4'd0, 2'b10, 3'b000, 3'b110, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1);
        resetDut();
        for (int k = 0; k < 257; k++) begin
            @(posedge clk); #1;
            applyStim(busyOnly);
            sb.push_back({FREEZE, (k == 0) ? 2'b00 : 2'b11});
            @(negedge clk);
            e = sb.pop_front();
            nChecks++;
            if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, StallCause} !== e) begin
                nFails++;
                $display("FAIL busy_hold step %0d got %b want %b", k,
                         {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, StallCause}, e);
            end
            if (k == 254) begin
                nChecks++; if (MemTimeout !== 1'b0) begin nFails++; $display("FAIL timeout_early got %b want 0", MemTimeout); end
                nChecks++; if (StallCount !== 8'd254) begin nFails++; $display("FAIL count_254 got %0d want 254", StallCount); end
            end
            if (k == 255) begin
                nChecks++; if (MemTimeout !== 1'b1) begin nFails++; $display("FAIL timeout_set got %b want 1", MemTimeout); end
                nChecks++; if (StallCount !== 8'd255) begin nFails++; $display("FAIL count_255 got %0d want 255", StallCount); end
            end
            if (k == 256) begin
                nChecks++; if (StallCount !== 8'd255) begin nFails++; $display("FAIL count_saturate got %0d want 255", StallCount); end
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            applyStim('0);
            @(negedge clk);
            nChecks++; if (MemTimeout !== 1'b1) begin nFails++; $display("FAIL timeout_sticky step %0d got %b want 1", k, MemTimeout); end
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            applyStim(busyHaz);
            @(negedge clk);
        end
        nChecks++; if (StallCause !== 2'b11) begin nFails++; $display("FAIL pre_reset_cause got %b want 11", StallCause); end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        nChecks++; if (StallCause !== 2'b00) begin nFails++; $display("FAIL async_rst_cause got %b want 00", StallCause); end
        nChecks++; if (StallCount !== 8'd0) begin nFails++; $display("FAIL async_rst_count got %0d want 0", StallCount); end
        nChecks++; if (MemTimeout !== 1'b0) begin nFails++; $display("FAIL async_rst_timeout got %b want 0", MemTimeout); end
        nChecks++; if (Pipe_Freeze !== 1'b1) begin nFails++; $display("FAIL rst_freeze_follows got %b want 1", Pipe_Freeze); end
        @(negedge clk);
        applyStim('0);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_store_data();
        test_br_hazards();
        test_flags();
        test_mem_wait();
        test_timeout_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller for the 5-stage WISC pipeline. It stalls the front end or bubbles the back end whenever a data, flag or memory dependency cannot be resolved by EX/MEM forwarding. It sits beside the ID stage, watching the IF/ID, ID/EX and EX/MEM pipeline registers and the memory busy lines. It drives PC/IF-ID write enables, ID/EX bubble insertion, IF/ID flush and whole-pipe freeze. It also keeps a registered stall-cause state, a saturating stall counter and a memory-timeout flag.

## Interface
Parameters:
- TIMEOUT, 255: consecutive DMem_Busy cycles after which MemTimeout sets.
- CNT_W, 16: StallCount width.

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- IFID_Rs, IFID_Rt  in  4 each  source registers of the instruction in ID.
- IFID_UsesRs, IFID_UsesRt  in  1 each  instruction in ID reads that operand.
- IFID_MemWrite  in  1  instruction in ID is SW; Rt is its store data.
- IFID_IsBR  in  1  register-indirect branch (BR); Rs is needed in ID.
- IFID_IsCondBr  in  1  conditional branch; reads flags in ID.
- IDEX_MemRead, IDEX_RegWrite, IDEX_SetsFlags  in  1 each  ID/EX control.
- IDEX_Rd  in  4  ID/EX destination.
- EXMem_MemRead  in  1  EX/MEM holds a load.
- EXMem_Rd  in  4  EX/MEM destination.
- BranchTaken  in  1  branch resolved taken in ID this cycle.
- DMem_Busy  in  1  data memory not ready; the whole pipe must hold.
- PC_Write  out  1  PC update enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  replace IF/ID with NOP.
- IDEX_Bubble  out  1  load NOP controls into ID/EX.
- Pipe_Freeze  out  1  hold EX/MEM and MEM/WB.
- StallCause  out  2  registered: 00 none, 01 data, 10 flag, 11 mem.
- StallCount  out  CNT_W  saturating count of stalled cycles.
- MemTimeout  out  1  sticky flag; cleared only by reset.

## Operation
Hazard terms are combinational on the current inputs. A destination of R0 never causes a hazard.

- **LU** (load-use): IDEX_MemRead & IDEX_Rd≠0 & ((IFID_UsesRs & IDEX_Rd==IFID_Rs) | (IFID_UsesRt & IDEX_Rd==IFID_Rt & !IFID_MemWrite)).
  - A SW whose only match is Rt store data does not stall; MEM-to-MEM forwarding covers it.
- **BRH**: IFID_IsBR & ((IDEX_RegWrite & IDEX_Rd≠0 & IDEX_Rd==IFID_Rs) | (EXMem_MemRead & EXMem_Rd≠0 & EXMem_Rd==IFID_Rs)).
- **FLG**: IFID_IsCondBr & IDEX_SetsFlags.
- DATA = LU | BRH.

FSM states: RUN, DSTALL, FSTALL, MWAIT. Next-state priority is DMem_Busy > DATA > FLG > none.
- Any state: DMem_Busy goes to MWAIT.
- Otherwise, DATA goes to DSTALL, FLG goes to FSTALL, and none goes to RUN.
- MWAIT exits only when DMem_Busy is low, then applies the same priority.

Outputs are combinational from the current inputs, using the same priority:
- **DMem_Busy**: Pipe_Freeze=1, PC_Write=0, IFID_Write=0, IDEX_Bubble=0, IFID_Flush=0. This is a full hold with nothing lost.
- **DATA or FLG**: PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0, Pipe_Freeze=0.
- **Otherwise**: PC_Write=1, IFID_Write=1, IDEX_Bubble=0, Pipe_Freeze=0, IFID_Flush=BranchTaken.
- BranchTaken is ignored while a stall or freeze is active. The branch resolves again on a later cycle.

Registered state:
- StallCause is the encoding of the state register.
- StallCount increments on every cycle where PC_Write=0, and holds at all-ones.
- A busy counter (8 bits) counts consecutive cycles with DMem_Busy=1 and clears when DMem_Busy is low. When it reaches TIMEOUT, MemTimeout sets and stays set.

## Timing
- On reset, asynchronously:
  - state RUN, StallCause=00, StallCount=0, busy counter 0, MemTimeout=0.
  - Combinational outputs follow the inputs. With idle inputs: PC_Write=1, IFID_Write=1, all others 0.
- Zero-cycle decision latency: outputs respond in the same cycle a hazard is visible. StallCause reflects it one cycle later.
- Stall lengths follow from the natural pipeline advance:
  - load-use: 1 cycle.
  - BR after an ALU producer: 1 cycle.
  - BR after a load producer: 2 cycles (ID/EX match, then EX/MEM load match).
  - flags: 1 cycle.
- Boundary cases:
  - DMem_Busy together with a data hazard: freeze only; no bubble is inserted. The hazard is re-evaluated after Busy drops.
  - Reset mid-stall returns to RUN immediately.
  - StallCount saturates and does not wrap.

## Test plan
- **Load-use**: LW R3 in ID/EX, ADD reading R3 in ID. Required: PC_Write=0 and IDEX_Bubble=1 for exactly 1 cycle; StallCause=01 on the next cycle; StallCount=1.
- **Store data**: LW R3 in ID/EX, SW with Rt=R3 and Rs=R5 in ID. Required: no stall, PC_Write=1.
- **BR after load**: LW R4, then BR R4. Required: 2 consecutive stall cycles, StallCount=2. Repeat with a producer to R0: no stall.
- **Flags**: ADD (sets flags) in ID/EX with a conditional branch in ID, and BranchTaken=1 asserted. Required: 1-cycle bubble with IFID_Flush=0; then IFID_Flush=1 on the following cycle.
- **Memory wait**: DMem_Busy high for 3 cycles during a load-use hazard. Required: Pipe_Freeze=1 and IDEX_Bubble=0 for 3 cycles, StallCause=11, then the 1-cycle data bubble; StallCount=4.
- **Timeout and reset**: hold DMem_Busy for 255 cycles. Required: MemTimeout=1 and it stays set after Busy drops. Then assert rst mid-stall: all registered outputs return to 0 asynchronously.
